line_fetcher: RTL
=================

LINE_FETCHER -- requirements
Module: line_fetcher

Interface
REQ-001 The module SHALL have parameter LINE_W, default 25, meaning the instruction line width in bits.
REQ-002 The module SHALL have parameter MEM_DEPTH, default 64, meaning the number of addressable program lines.
REQ-003 The module SHALL have port clk, input, 1, meaning the single system clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, meaning the reset; it is asynchronous and active-low.
REQ-005 The module SHALL have port start, input, 1, meaning a level or pulse that begins a fetch run from address 0.
REQ-006 The module SHALL have port mem_rd, output, 1, meaning the read strobe to the program memory.
REQ-007 The module SHALL have port mem_addr, output, 6, meaning the program memory read address.
REQ-008 The module SHALL have port mem_data, input, LINE_W, meaning read data, valid exactly one cycle after mem_rd.
REQ-009 The module SHALL have port line, output, LINE_W, meaning the current line presented to the Controller.
REQ-010 The module SHALL have port line_valid, output, 1, meaning line holds an unconsumed program line.
REQ-011 The module SHALL have port line_taken, input, 1, meaning a one-cycle pulse from the Controller (its readLine) that consumes line.
REQ-012 The module SHALL have port fetch_done, output, 1, meaning the program is exhausted and all lines are consumed.
REQ-013 The module SHALL have port line_count, output, 7, meaning the number of lines consumed in this run.

Function
REQ-014 The states SHALL be IDLE, FETCH, DRAIN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL move the FSM to FETCH, clear line_count and fetch_done, and reset the next address to 0.
REQ-016 start SHALL be ignored in FETCH and DRAIN.
REQ-017 In FETCH, mem_rd SHALL assert when (FIFO occupancy + outstanding reads) < 2, next address < MEM_DEPTH, and no EOF has been seen.
REQ-018 Each mem_rd SHALL increment the next address; at most one read SHALL be outstanding per cycle.
REQ-019 The returned mem_data SHALL be pushed into a 2-entry FIFO one cycle after mem_rd.
REQ-020 If the returned mem_data equals all-ones (EOF), it SHALL NOT be pushed; instead the eof_seen flag SHALL be set and no further mem_rd SHALL be issued.
REQ-021 line SHALL equal the FIFO head, and line_valid SHALL equal FIFO-not-empty.
REQ-022 Latency from start to line_valid SHALL be 3 cycles: FETCH entry, then mem_rd, then push.
REQ-023 line_taken with line_valid=1 SHALL pop the head and increment line_count; line_taken with line_valid=0 SHALL be ignored.
REQ-024 A push and a pop in the same cycle SHALL keep occupancy unchanged and preserve order.
REQ-025 A push SHALL never occur into a full FIFO; this is guaranteed by REQ-017.
REQ-026 FETCH SHALL move to DRAIN when eof_seen is set, or when address MEM_DEPTH-1 (63) has been read.
REQ-027 DRAIN SHALL move to DONE when the FIFO is empty and no read is outstanding.
REQ-028 fetch_done SHALL be 1 in DONE only.
REQ-029 line_count SHALL saturate at 64.

Reset
REQ-030 When rst=0, the module SHALL asynchronously enter IDLE with mem_rd=0, mem_addr=0, line=0, line_valid=0, fetch_done=0, line_count=0, the FIFO emptied, eof_seen cleared and the outstanding flag cleared.
REQ-031 A reset asserted mid-run SHALL discard any outstanding read; the data returned in the cycle after reset release SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold LINE_W, MEM_DEPTH, ADDR_W=6, the EOF pattern (all-ones of LINE_W) and the fetch-state enumeration.
REQ-033 The 2-entry FIFO SHALL be a separate sub-module named line_fifo2, with ports push, pop, din, dout, empty, full and count.

Verification
REQ-034 Scenario "basic": memory holds 0..5 at addresses 0..5 and EOF at address 6; start; take each line 10 cycles after it becomes valid -> lines 0..5 appear in order, line_count=6, fetch_done=1, and no mem_rd is issued after address 6.
REQ-035 Scenario "back-to-back": the Controller holds line_taken=1 continuously for a 64-line program with no EOF -> 64 lines delivered in order, mem_rd is never issued with a full pipeline, line_count=64, and DONE is reached after address 63.
REQ-036 Scenario "stall": line_taken is held at 0 for 50 cycles after start -> exactly 2 mem_rd pulses occur, line stays at word 0, and line_valid stays 1.
REQ-037 Scenario "reset mid-run": rst is dropped while a read is outstanding at address 3 -> all outputs go to 0 immediately; after release with start=0 the module stays in IDLE and mem_rd=0.
REQ-038 Scenario "EOF first": address 0 holds all-ones -> line_valid never asserts and fetch_done=1 within 4 cycles of start, with line_count=0.
REQ-039 Scenario "restart": start is pulsed in DONE -> line_count clears to 0, mem_addr returns to 0, and the program is fetched again.

Source files
------------

// File: rtl/line_fetcher_pkg.sv
// Shared constants and fetch-state encoding for the program line fetcher.
package line_fetcher_pkg;

    localparam int unsigned LINE_W       = 25;
    localparam int unsigned MEM_DEPTH    = 64;
    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned CNT_W        = 7;
    localparam int unsigned LINE_CNT_MAX = 64;

    localparam logic [LINE_W-1:0] EOF_LINE = {LINE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/line_fifo2.sv
// Two-entry line buffer between the program memory and the Controller.
module line_fifo2 #(
    parameter int unsigned W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop & (count_q != 2'd0);
    assign do_push = push & ((count_q != 2'd2) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign dout  = mem_q[rd_q];
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign count = count_q;

endmodule

// File: rtl/line_fetcher.sv
// Streams program lines from memory into a 2-deep buffer for the Controller,
// stopping at the EOF word or at the last address.
module line_fetcher #(
    parameter int unsigned LINE_W    = line_fetcher_pkg::LINE_W,
    parameter int unsigned MEM_DEPTH = line_fetcher_pkg::MEM_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                mem_rd,
    output logic [line_fetcher_pkg::ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]                   mem_data,
    output logic [LINE_W-1:0]                   line,
    output logic                                line_valid,
    input  logic                                line_taken,
    output logic                                fetch_done,
    output logic [line_fetcher_pkg::CNT_W-1:0]  line_count
);
    import line_fetcher_pkg::*;

    localparam logic [LINE_W-1:0] EOF_WORD  = {LINE_W{1'b1}};
    localparam logic [CNT_W-1:0]  DEPTH_END = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(LINE_CNT_MAX);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [CNT_W-1:0] naddr_q;
    logic [CNT_W-1:0] naddr_d;
    logic [CNT_W-1:0] line_count_d;
    logic             outstanding_q;
    logic             eof_seen_q;
    logic             eof_seen_d;
    logic             fetch_done_d;
    logic             ret_eof_c;
    logic             eof_hit_c;
    logic             room_c;
    logic             push_c;
    logic             pop_c;
    logic [1:0]       fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // Returning EOF blocks a read in the same cycle so nothing past EOF is fetched.
    assign ret_eof_c = outstanding_q & (mem_data == EOF_WORD);
    assign eof_hit_c = eof_seen_q | ret_eof_c;
    assign room_c    = (3'(fifo_count) + 3'(outstanding_q)) < 3'd2;
    assign mem_rd    = (state_q == ST_FETCH) & room_c & ~fifo_full
                     & (naddr_q < DEPTH_END) & ~eof_hit_c;
    assign push_c    = outstanding_q & (mem_data != EOF_WORD);
    assign pop_c     = line_taken & ~fifo_empty;
    assign mem_addr  = naddr_q[ADDR_W-1:0];

    line_fifo2 #(.W(LINE_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (mem_data),
        .dout  (line),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign line_valid = ~fifo_empty;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        naddr_d      = naddr_q;
        eof_seen_d   = eof_seen_q | ret_eof_c;
        line_count_d = line_count;
        if (pop_c && (line_count < CNT_SAT)) begin
            line_count_d = line_count + CNT_W'(1);
        end
        if (mem_rd) begin
            naddr_d = naddr_q + CNT_W'(1);
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    naddr_d      = '0;
                    eof_seen_d   = 1'b0;
                    line_count_d = '0;
                end
            end
            ST_FETCH: begin
                if (eof_hit_c || (naddr_d == DEPTH_END)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !outstanding_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        fetch_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            naddr_q       <= '0;
            outstanding_q <= 1'b0;
            eof_seen_q    <= 1'b0;
            fetch_done    <= 1'b0;
            line_count    <= '0;
        end else begin
            state_q       <= state_d;
            naddr_q       <= naddr_d;
            outstanding_q <= mem_rd;
            eof_seen_q    <= eof_seen_d;
            fetch_done    <= fetch_done_d;
            line_count    <= line_count_d;
        end
    end

endmodule
